// File: rtl/frogg_game_ctrl_pkg.sv
// frogg_game_ctrl_pkg: game FSM encodings and playfield geometry shared with the frog controller
package frogg_game_ctrl_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, HIT = 3'd2, WIN = 3'd3, OVER = 3'd4} state_t;
  localparam int game_width = 40;
  localparam int game_height = 30;
endpackage

// File: rtl/frogg_game_ctrl_if.sv
// frogg_game_ctrl_if: scan-side draw/position inputs and game status returned to the frog side
interface frogg_game_ctrl_if;
  logic frame_start, draw_frog, draw_car, start, frog_respawn, freeze;
  logic [9:0] frog_y;
  logic [1:0] lives;
  logic [7:0] score;
  logic [2:0] state;
  modport master (
    output frame_start, draw_frog, draw_car, frog_y, start,
    input frog_respawn, freeze, lives, score, state
  );
  modport slave (
    input frame_start, draw_frog, draw_car, frog_y, start,
    output frog_respawn, freeze, lives, score, state
  );
endinterface

// File: rtl/frogg_frame_timer.sv
// frogg_frame_timer: counts frame starts since clear; done fires on the limit-th one
module frogg_frame_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       frame_start,
  input  logic [7:0] limit,
  output logic       done
);
  logic [7:0] cnt;
  assign done = !clear && frame_start && cnt == limit - 8'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= 8'd0;
    else cnt <= clear ? 8'd0 : cnt + 8'(frame_start);
endmodule

// File: rtl/frogg_game_ctrl.sv
// frogg_game_ctrl: collision/goal detection, game FSM, lives, score and frog respawn control
module frogg_game_ctrl
  import frogg_game_ctrl_pkg::*;
#(
  parameter int start_lives = 3,
  parameter int hit_frames  = 60,
  parameter int win_frames  = 30,
  parameter int goal_row    = 0,
  parameter int score_max   = 255
) (
  input logic clk,
  input logic rst,
  frogg_game_ctrl_if.slave g
);
  state_t st;
  logic hit, start_q, respawn, freeze, done, start_rise, overlap, hold;
  logic [1:0] lives;
  logic [7:0] score;
  assign start_rise = g.start && !start_q;
  assign overlap = g.draw_frog && g.draw_car && st == PLAY;
  assign hold = st == HIT || st == WIN;
  frogg_frame_timer u_timer (
    .clk(clk), .rst(rst), .clear(!hold), .frame_start(g.frame_start),
    .limit(st == HIT ? 8'(hit_frames) : 8'(win_frames)), .done(done)
  );
  // overlap on a frame-start cycle belongs to the frame that is just beginning
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      start_q <= 1'b0;
      hit <= 1'b0;
    end else begin
      start_q <= g.start;
      hit <= g.frame_start ? overlap : hit || overlap;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      lives <= 2'd0;
      score <= 8'd0;
      respawn <= 1'b0;
      freeze <= 1'b1;
    end else begin
      respawn <= 1'b0;
      case (st)
        IDLE, OVER: if (start_rise) begin
          st <= PLAY;
          lives <= 2'(start_lives);
          score <= 8'd0;
          respawn <= 1'b1;
          freeze <= 1'b0;
        end
        PLAY: if (g.frame_start) begin
          if (hit) begin
            st <= HIT;
            lives <= lives - {1'b0, lives != 2'd0};
            freeze <= 1'b1;
          end else if (g.frog_y <= 10'(goal_row)) begin
            st <= WIN;
            score <= score >= 8'(score_max) ? score : score + 8'd1;
            freeze <= 1'b1;
          end
        end
        HIT: if (done) begin
          st <= lives == 2'd0 ? OVER : PLAY;
          respawn <= lives != 2'd0;
          freeze <= lives == 2'd0;
        end
        WIN: if (done) begin
          st <= PLAY;
          respawn <= 1'b1;
          freeze <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  assign g.frog_respawn = respawn;
  assign g.freeze = freeze;
  assign g.lives = lives;
  assign g.score = score;
  assign g.state = st;
endmodule

// File: tb/tb_frogg_game_ctrl.sv
// tb_frogg_game_ctrl: vector table plus hand sequences, expectations queued and popped per check
module tb_frogg_game_ctrl;
  typedef struct {
    string name;
    logic [2:0] st;
    logic [1:0] lives;
    logic [7:0] score;
    logic frz;
    int resp;
  } exp_t;
  typedef struct {
    logic ov;
    logic [9:0] y;
    int n;
    exp_t e;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  int errors = 0, checks = 0, resp_cnt = 0;
  exp_t sb[$];
  vec_t vecs[$];
  frogg_game_ctrl_if g();
  frogg_game_ctrl dut (.clk(clk), .rst(rst), .g(g));
  always #5 clk = ~clk;
  always @(negedge clk) if (g.frog_respawn) resp_cnt++;
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
  function automatic exp_t mk(string name, int st, int lives, int score, int frz, int resp);
    exp_t e;
    e.name = name;
    e.st = 3'(st);
    e.lives = 2'(lives);
    e.score = 8'(score);
    e.frz = 1'(frz);
    e.resp = resp;
    return e;
  endfunction
  function automatic vec_t mv(int ov, int y, int n, exp_t e);
    vec_t v;
    v.ov = 1'(ov);
    v.y = 10'(y);
    v.n = n;
    v.e = e;
    return v;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic expect_(string name, int st, int lives, int score, int frz, int resp);
    sb.push_back(mk(name, st, lives, score, frz, resp));
  endtask
  task automatic check();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = sb.pop_front();
    cmp({e.name, ".state"}, int'(g.state), int'(e.st));
    cmp({e.name, ".lives"}, int'(g.lives), int'(e.lives));
    cmp({e.name, ".score"}, int'(g.score), int'(e.score));
    cmp({e.name, ".freeze"}, int'(g.freeze), int'(e.frz));
    cmp({e.name, ".respawns"}, resp_cnt, e.resp);
  endtask
  // frame: start pulse, frog pixel (car too if ov), car-only pixel, blank
  task automatic frame(input logic ov, input logic [9:0] y);
    g.frog_y = y;
    g.frame_start = 1'b1;
    step();
    g.frame_start = 1'b0;
    g.draw_frog = 1'b1;
    g.draw_car = ov;
    step();
    g.draw_frog = 1'b0;
    g.draw_car = 1'b1;
    step();
    g.draw_car = 1'b0;
    step();
  endtask
  task automatic frames(input int n, input logic ov, input logic [9:0] y);
    for (int i = 0; i < n; i++) frame(ov, y);
  endtask
  task automatic start_pulse();
    g.start = 1'b0;
    step();
    g.start = 1'b1;
    step();
    g.start = 1'b0;
    step();
  endtask
  initial begin
    vecs.push_back(mv(0, 100, 2, mk("idle_play", 1, 3, 0, 0, 1)));
    vecs.push_back(mv(1, 100, 2, mk("hit", 2, 2, 0, 1, 1)));
    vecs.push_back(mv(0, 100, 59, mk("hit_hold", 2, 2, 0, 1, 1)));
    vecs.push_back(mv(0, 100, 1, mk("hit_release", 1, 2, 0, 0, 2)));
    vecs.push_back(mv(0, 0, 1, mk("goal", 3, 2, 1, 1, 2)));
    vecs.push_back(mv(0, 0, 29, mk("win_hold", 3, 2, 1, 1, 2)));
    vecs.push_back(mv(0, 100, 1, mk("win_release", 1, 2, 1, 0, 3)));
    vecs.push_back(mv(1, 100, 1, mk("overlap_arm", 1, 2, 1, 0, 3)));
    vecs.push_back(mv(0, 0, 1, mk("hit_and_goal", 2, 1, 1, 1, 3)));
    vecs.push_back(mv(0, 100, 59, mk("hg_hold", 2, 1, 1, 1, 3)));
    vecs.push_back(mv(0, 100, 1, mk("hg_release", 1, 1, 1, 0, 4)));
    g.frame_start = 1'b0;
    g.draw_frog = 1'b0;
    g.draw_car = 1'b0;
    g.frog_y = 10'd100;
    g.start = 1'b0;
    rst = 1'b1;
    step();
    step();
    expect_("reset", 0, 0, 0, 1, 0);
    check();
    cmp("reset.respawn_level", int'(g.frog_respawn), 0);
    rst = 1'b0;
    step();
    start_pulse();
    expect_("start", 1, 3, 0, 0, 1);
    check();
    for (int i = 0; i < vecs.size(); i++) begin
      sb.push_back(vecs[i].e);
      frames(vecs[i].n, vecs[i].ov, vecs[i].y);
      check();
    end
    // last life lost with start held high: OVER must not auto-restart
    g.start = 1'b1;
    frame(1'b1, 10'd100);
    frame(1'b0, 10'd100);
    expect_("last_hit", 2, 0, 1, 1, 4);
    check();
    frames(60, 1'b0, 10'd100);
    expect_("over", 4, 0, 1, 1, 4);
    check();
    frames(2, 1'b0, 10'd100);
    expect_("start_held", 4, 0, 1, 1, 4);
    check();
    start_pulse();
    expect_("restart", 1, 3, 0, 0, 5);
    check();
    for (int k = 0; k < 3; k++) begin
      frame(1'b1, 10'd100);
      frame(1'b0, 10'd100);
      expect_($sformatf("hit%0d", k), 2, 2 - k, 0, 1, 5 + k);
      check();
      frames(60, 1'b0, 10'd100);
      expect_($sformatf("hit%0d_end", k), k < 2 ? 1 : 4, 2 - k, 0, k < 2 ? 0 : 1, k < 2 ? 6 + k : 7);
      check();
    end
    start_pulse();
    expect_("restart2", 1, 3, 0, 0, 8);
    check();
    for (int i = 1; i <= 256; i++) begin
      frame(1'b0, 10'd0);
      if (i == 1 || i >= 255) begin
        expect_($sformatf("cross%0d", i), 3, 3, i > 255 ? 255 : i, 1, 8 + i - 1);
        check();
      end
      frames(30, 1'b0, 10'd100);
    end
    expect_("saturated", 1, 3, 255, 0, 264);
    check();
    frame(1'b1, 10'd100);
    frame(1'b0, 10'd100);
    expect_("pre_reset_hit", 2, 2, 255, 1, 264);
    check();
    frames(5, 1'b0, 10'd100);
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_("async_reset", 0, 0, 0, 1, 264);
    check();
    cmp("async_reset.respawn_level", int'(g.frog_respawn), 0);
    step();
    rst = 1'b0;
    frames(3, 1'b0, 10'd0);
    expect_("post_reset_idle", 0, 0, 0, 1, 264);
    check();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
